// File: rtl/debounce_trigger_pkg.sv
// Shared constants for the push-button debounce front end of the 1 s timer.
// Holds the clock rate, the derived debounce default and the FSM state encodings.
package debounce_trigger_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  // 20 ms of stable input at the system clock rate
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned CNT_W_DEFAULT           = 20;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE         = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [STATE_W-1:0] ST_HELD         = 2'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE_WAIT = 2'd3;

  // Debounced level is high whenever the button is considered down.
  function automatic logic state_is_pressed(input logic [STATE_W-1:0] st);
    return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/debounce_trigger_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous reset to a configurable value.
// Shared by every asynchronous board input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_trigger.sv
// Synchronises and debounces an active-low push-button and emits one start_trigger
// (or dropped, when the timer is busy) pulse per accepted press.
module debounce_trigger
  import debounce_trigger_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic busy,
  output logic start_trigger,
  output logic dropped,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic               btn_press_raw;
  logic               p;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               start_next;
  logic               dropped_next;
  logic               level_next;

  assign btn_press_raw = ~btn_n;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_press_raw),
    .q     (p)
  );

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and pulse decisions; busy only matters on the acceptance edge
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    start_next   = 1'b0;
    dropped_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (p) begin
          state_next = ST_PRESS_WAIT;
          cnt_next   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!p) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next   = ST_HELD;
          start_next   = ~busy;
          dropped_next = busy;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!p) begin
          state_next = ST_RELEASE_WAIT;
          cnt_next   = '0;
        end
      end

      ST_RELEASE_WAIT: begin
        if (p) begin
          state_next = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    level_next = state_is_pressed(state_next);
  end

  // Output registers, updated on the same edge as the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_trigger <= 1'b0;
      dropped       <= 1'b0;
      btn_level     <= 1'b0;
    end else begin
      start_trigger <= start_next;
      dropped       <= dropped_next;
      btn_level     <= level_next;
    end
  end

endmodule

// File: tb/tb_debounce_trigger.sv
// Scoreboard bench for debounce_trigger with N=8: directed press scenarios push
// expected pulse/level events; an independent monitor pops and compares them.
module tb_debounce_trigger;

  localparam int N = 8;

  typedef struct {
    int         e;
    logic [1:0] kind;   // {start_trigger, dropped}
  } pulse_t;

  typedef struct {
    int   e;
    logic lvl;
  } lvl_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b1;
  logic busy = 1'b0;
  logic start_trigger;
  logic dropped;
  logic btn_level;

  int edge_no = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic last_lvl = 1'b0;

  pulse_t exp_pulse[$];
  lvl_t   exp_lvl[$];

  debounce_trigger #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .busy          (busy),
    .start_trigger (start_trigger),
    .dropped       (dropped),
    .btn_level     (btn_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
  endtask

  task automatic hold(input logic v, input int n);
    btn_n = v;
    repeat (n) @(negedge clk);
  endtask

  // press first sampled at edge k: pulse and level rise at k+N+2
  task automatic expect_press(input int k, input logic bsy);
    pulse_t pe;
    lvl_t   le;
    pe.e    = k + N + 2;
    pe.kind = bsy ? 2'b01 : 2'b10;
    le.e    = k + N + 2;
    le.lvl  = 1'b1;
    exp_pulse.push_back(pe);
    exp_lvl.push_back(le);
  endtask

  // release first sampled at edge r: level falls at r+N+2
  task automatic expect_release(input int r);
    lvl_t le;
    le.e   = r + N + 2;
    le.lvl = 1'b0;
    exp_lvl.push_back(le);
  endtask

  // Monitor: compare every observed pulse and level change against the scoreboard
  always @(negedge clk) begin
    pulse_t pe;
    lvl_t   le;
    if (reset) begin
      last_lvl = 1'b0;
    end else begin
      if (start_trigger || dropped) begin
        if (exp_pulse.size() == 0) begin
          chk("unexpected_pulse", edge_no, -1);
        end else begin
          pe = exp_pulse.pop_front();
          chk("pulse_edge", edge_no, pe.e);
          chk("pulse_kind", int'({start_trigger, dropped}), int'(pe.kind));
        end
      end
      if (btn_level !== last_lvl) begin
        if (exp_lvl.size() == 0) begin
          chk("unexpected_level", edge_no, -1);
        end else begin
          le = exp_lvl.pop_front();
          chk("level_edge", edge_no, le.e);
          chk("level_value", int'(btn_level), int'(le.lvl));
        end
        last_lvl = btn_level;
      end
    end
  end

  initial begin
    int k;
    int r;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_start_trigger", int'(start_trigger), 0);
    chk("reset_dropped", int'(dropped), 0);
    chk("reset_btn_level", int'(btn_level), 0);
    reset = 1'b0;
    hold(1'b1, 5);

    // clean press, not busy
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, 30);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 20);

    // press bounce: never N stable cycles, then a steady press
    for (int i = 0; i < 10; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 2);
    end
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, 20);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 20);

    // busy press: dropped only, nothing after busy falls
    busy = 1'b1;
    k = edge_no + 1;
    expect_press(k, 1'b1);
    hold(1'b0, 20);
    busy = 1'b0;
    hold(1'b0, 20);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 20);

    // long hold with release bounce
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, 200);
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 20);

    // reset while in PRESS_WAIT with cnt=5, button still held
    k = edge_no + 1;
    hold(1'b0, 8);
    reset = 1'b1;
    #1;
    chk("midreset_start_trigger", int'(start_trigger), 0);
    chk("midreset_dropped", int'(dropped), 0);
    chk("midreset_btn_level", int'(btn_level), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, 20);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 20);

    // back-to-back presses at the minimum spacing of 2N+4
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, N + 2);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, N + 2);
    k = edge_no + 1;
    expect_press(k, 1'b0);
    hold(1'b0, N + 2);
    r = edge_no + 1;
    expect_release(r);
    hold(1'b1, 30);

    chk("pulses_outstanding", exp_pulse.size(), 0);
    chk("levels_outstanding", exp_lvl.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
